fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_wrap_ctr.sv | 42 ++++
 rtl/fir_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and state encoding for the FIR sequencing controller.
package fir_pkg;

  localparam int TAPS_DEF = 64;
  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 6;

  // Sequencer states: IDLE=0, LOAD_COEF=1, RUN=2
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_COEF = 2'd1,
    RUN       = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_wrap_ctr.sv
// AW-bit address counter: synchronous clear, count enable, wraps TAPS-1 -> 0.
// at_last_o flags the final index so the owner can detect the end of a pass.
module fir_wrap_ctr #(
  parameter int AW   = 6,
  parameter int TAPS = 64
) (
  input  logic          clk_10kHz,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o,
  output logic          at_last_o
);

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // next count: clear wins over increment, increment wraps at the last tap
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign at_last_o = (cnt_q == LAST);

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: loads TAPS coefficients after a start pulse,
// then streams samples into a circular buffer and pulses frame_start for
// every sample written once the buffer is full.
// Optional feature: define FIR_SEQ_RELOAD_EN to add the coef_reload input,
// which sends a running block back to coefficient loading.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk_10kHz,
  input  logic          reset,
  input  logic          start,
`ifdef FIR_SEQ_RELOAD_EN
  input  logic          coef_reload,
`endif
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  output logic          coef_ready,
  input  logic          samp_valid,
  input  logic [DW-1:0] samp_data,
  output logic          samp_ready,
  output logic [DW-1:0] cin,
  output logic [AW-1:0] caddr,
  output logic          cload,
  output logic [DW-1:0] xin,
  output logic [AW-1:0] xaddr,
  output logic          xload,
  output logic          frame_start,
  output logic          primed,
  output logic          busy
);

  localparam logic [AW:0] FILL_MAX  = (AW + 1)'(TAPS);
  localparam logic [AW:0] FILL_LAST = (AW + 1)'(TAPS - 1);

  fir_state_e    state_q, state_d;
  logic          enter_load;
  logic          reload_req;
  logic          coef_acc;
  logic          samp_acc;

  logic [AW-1:0] cidx;
  logic          cidx_last;
  logic [AW-1:0] wptr;
  logic          wptr_last;

  logic          cload_q;
  logic [AW-1:0] caddr_q;
  logic [DW-1:0] cin_q;
  logic          xload_q;
  logic [AW-1:0] xaddr_q;
  logic [DW-1:0] xin_q;
  logic [AW:0]   fill_q;
  logic          primed_q;
  logic          frame_start_q;

`ifdef FIR_SEQ_RELOAD_EN
  assign reload_req = (state_q == RUN) && coef_reload;
`else
  assign reload_req = 1'b0;
`endif

  // handshakes depend only on the registered state, never on the valids
  assign coef_acc = coef_valid && (state_q == LOAD_COEF);
  assign samp_acc = samp_valid && (state_q == RUN);

  // next state, ready/busy outputs and the load-entry clear
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    coef_ready = 1'b0;
    samp_ready = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = LOAD_COEF;
          enter_load = 1'b1;
        end
      end
      LOAD_COEF: begin
        coef_ready = 1'b1;
        if (coef_valid && cidx_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        samp_ready = 1'b1;
        if (reload_req) begin
          state_d    = LOAD_COEF;
          enter_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  fir_wrap_ctr #(.AW(AW), .TAPS(TAPS)) u_coef_idx (
    .clk_10kHz (clk_10kHz),
    .reset     (reset),
    .clr_i     (enter_load),
    .en_i      (coef_acc),
    .cnt_o     (cidx),
    .at_last_o (cidx_last)
  );

  fir_wrap_ctr #(.AW(AW), .TAPS(TAPS)) u_samp_wptr (
    .clk_10kHz (clk_10kHz),
    .reset     (reset),
    .clr_i     (enter_load),
    .en_i      (samp_acc),
    .cnt_o     (wptr),
    .at_last_o (wptr_last)
  );

  // coefficient memory write port: strobe for one cycle, address/data hold
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      cload_q <= 1'b0;
      caddr_q <= '0;
      cin_q   <= '0;
    end else begin
      cload_q <= coef_acc;
      if (coef_acc) begin
        caddr_q <= cidx;
        cin_q   <= coef_data;
      end
    end
  end

  // sample memory write port: same one-cycle strobe, written at the write pointer
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      xload_q <= 1'b0;
      xaddr_q <= '0;
      xin_q   <= '0;
    end else begin
      xload_q <= samp_acc;
      if (samp_acc) begin
        xaddr_q <= wptr;
        xin_q   <= samp_data;
      end
    end
  end

  // fill level and primed flag; primed rises with the strobe of the TAPS-th write.
  // A reload clears both on the same edge, so a sample taken then cannot prime.
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (enter_load) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else if (samp_acc) begin
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
      if (fill_q == FILL_LAST) begin
        primed_q <= 1'b1;
      end
    end
  end

  // frame pulse one cycle after any sample write seen with the buffer primed
  always_ff @(posedge clk_10kHz or posedge reset) begin
    if (reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= xload_q && primed_q;
    end
  end

  assign cload       = cload_q;
  assign caddr       = caddr_q;
  assign cin         = cin_q;
  assign xload       = xload_q;
  assign xaddr       = xaddr_q;
  assign xin         = xin_q;
  assign primed      = primed_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl. The driver tracks the sequencer at the
// level of "loading coefficient k" / "running with n samples taken" and pushes
// the write strobes and frame pulses it expects; a negedge monitor pops them.
// Define FIR_SEQ_RELOAD_EN to also exercise coef_reload.
`timescale 1ns/1ps
module tb_fir_seq_ctrl;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int MASK = (1 << DW) - 1;

  logic          clk_10kHz = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          coef_reload = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DW-1:0] coef_data = '0;
  logic          coef_ready;
  logic          samp_valid = 1'b0;
  logic [DW-1:0] samp_data = '0;
  logic          samp_ready;
  logic [DW-1:0] cin;
  logic [AW-1:0] caddr;
  logic          cload;
  logic [DW-1:0] xin;
  logic [AW-1:0] xaddr;
  logic          xload;
  logic          frame_start;
  logic          primed;
  logic          busy;

  fir_seq_ctrl #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .clk_10kHz   (clk_10kHz),
    .reset       (reset),
    .start       (start),
`ifdef FIR_SEQ_RELOAD_EN
    .coef_reload (coef_reload),
`endif
    .coef_valid  (coef_valid),
    .coef_data   (coef_data),
    .coef_ready  (coef_ready),
    .samp_valid  (samp_valid),
    .samp_data   (samp_data),
    .samp_ready  (samp_ready),
    .cin         (cin),
    .caddr       (caddr),
    .cload       (cload),
    .xin         (xin),
    .xaddr       (xaddr),
    .xload       (xload),
    .frame_start (frame_start),
    .primed      (primed),
    .busy        (busy)
  );

  always #5 clk_10kHz = ~clk_10kHz;

  typedef struct {
    int cyc;
    int addr;
    int data;
    bit pr;
  } item_t;

  item_t cq[$];
  item_t xq[$];
  int    fq[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int fs_count = 0;

  // abstract model: 0 idle, 1 loading coefficients, 2 running
  int mstate = 0;
  int mcidx = 0;
  int mwp = 0;
  int mfill = 0;

  always @(posedge clk_10kHz) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one clock of stimulus; the model decides what the edge should accept
  task automatic go(input bit st, input bit cv, input int cd, input bit sv, input int sd, input bit rl);
    int nxt;
    bit pr;
    start       = st;
    coef_valid  = cv;
    coef_data   = cd[DW-1:0];
    samp_valid  = sv;
    samp_data   = sd[DW-1:0];
    coef_reload = rl;
    nxt = mstate;
    case (mstate)
      0: if (st) begin
        nxt = 1; mcidx = 0; mwp = 0; mfill = 0;
      end
      1: if (cv) begin
        cq.push_back('{cyc + 1, mcidx, cd & MASK, 1'b0});
        mcidx++;
        if (mcidx == TAPS) nxt = 2;
      end
      2: begin
        if (sv) begin
          pr = !rl && (mfill + 1 >= TAPS);
          xq.push_back('{cyc + 1, mwp, sd & MASK, pr});
          if (pr) fq.push_back(cyc + 2);
          mwp = (mwp + 1) % TAPS;
          if (!rl) mfill++;
        end
        if (rl) begin
          nxt = 1; mcidx = 0; mwp = 0; mfill = 0;
        end
      end
      default: nxt = 0;
    endcase
    @(posedge clk_10kHz);
    #1;
    mstate = nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; coef_valid = 1'b0; samp_valid = 1'b0; coef_reload = 1'b0;
    cq.delete(); xq.delete(); fq.delete();
    mstate = 0; mcidx = 0; mwp = 0; mfill = 0;
    #1;
    chk("rst_cload", cload, 0);
    chk("rst_xload", xload, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_primed", primed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_caddr", caddr, 0);
    chk("rst_xaddr", xaddr, 0);
    chk("rst_cin", cin, 0);
    chk("rst_xin", xin, 0);
    chk("rst_readys", {coef_ready, samp_ready}, 0);
    @(posedge clk_10kHz);
    @(posedge clk_10kHz);
    #1;
    reset = 1'b0;
  endtask

  // load all coefficients with random data and random gaps
  task automatic load_random(input int limit);
    int guard = 0;
    while (mstate == 1 && guard < limit) begin
      go($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), $urandom, 1'b0);
      guard++;
    end
    chk("load_done", mstate, 2);
  endtask

  // monitor: strobes against the scoreboard, readys/busy against the model
  always @(negedge clk_10kHz) begin : mon
    item_t it;
    bit ex;
    if (!reset) begin
      chk("ready_busy", {coef_ready, samp_ready, busy},
          {mstate == 1, mstate == 2, mstate != 0});
      while (cq.size() > 0 && cq[0].cyc < cyc) begin
        chk("cload_late", cq[0].cyc, cyc);
        void'(cq.pop_front());
      end
      ex = cq.size() > 0 && cq[0].cyc == cyc;
      if (ex || cload) begin
        chk("cload_present", cload, ex);
        if (ex && cload) begin
          it = cq.pop_front();
          chk("caddr", caddr, it.addr);
          chk("cin", cin, it.data);
          $display("cload  cyc=%0d caddr=%0d cin=%0d", cyc, caddr, cin);
        end else if (ex) begin
          void'(cq.pop_front());
        end
      end
      while (xq.size() > 0 && xq[0].cyc < cyc) begin
        chk("xload_late", xq[0].cyc, cyc);
        void'(xq.pop_front());
      end
      ex = xq.size() > 0 && xq[0].cyc == cyc;
      if (ex || xload) begin
        chk("xload_present", xload, ex);
        if (ex && xload) begin
          it = xq.pop_front();
          chk("xaddr", xaddr, it.addr);
          chk("xin", xin, it.data);
          chk("primed_at_xload", primed, it.pr);
          $display("xload  cyc=%0d xaddr=%0d xin=%0d primed=%0d", cyc, xaddr, xin, primed);
        end else if (ex) begin
          void'(xq.pop_front());
        end
      end
      while (fq.size() > 0 && fq[0] < cyc) begin
        chk("frame_late", fq[0], cyc);
        void'(fq.pop_front());
      end
      ex = fq.size() > 0 && fq[0] == cyc;
      if (ex || frame_start) begin
        chk("frame_start", frame_start, ex);
        if (ex) void'(fq.pop_front());
        if (frame_start) begin
          fs_count++;
          $display("frame  cyc=%0d", cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    idle(2);

    // samples and coefficients offered while idle are ignored
    for (int i = 0; i < 6; i++) go(1'b0, 1'b1, i, 1'b1, i, 1'b0);
    chk("idle_no_fill", primed, 0);

    // start, then 64 back-to-back coefficients with data = index
    go(1'b1, 1'b0, 0, 1'b1, 7, 1'b0);
    for (int k = 0; k < TAPS; k++) go(k == 10, 1'b1, k, 1'b1, 9, 1'b0);
    chk("run_after_load", mstate, 2);

    // 70 back-to-back samples, data = 100+n, with start asserted now and then
    fs_count = 0;
    for (int n = 0; n < 70; n++) go((n % 9) == 0, 1'b0, 0, 1'b1, 100 + n, 1'b0);
    idle(3);
    chk("frame_count_70", fs_count, 7);
    chk("primed_held", primed, 1);

    // random sample traffic with gaps
    for (int i = 0; i < 60; i++) go($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, 1'b0);
    idle(3);

    // reset in the middle of a coefficient load
    go(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    do_reset();
    go(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 30; k++) go(1'b0, 1'b1, 500 + k, 1'b0, 0, 1'b0);
    do_reset();
    chk("post_rst_state", busy, 0);
    go(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    load_random(1000);

    // fill the buffer and keep going with random gaps
    for (int i = 0; i < 200; i++) go(1'b0, 1'b0, 0, $urandom_range(0, 3) != 0, $urandom, 1'b0);
    idle(3);
    chk("primed_random", primed, 1);

`ifdef FIR_SEQ_RELOAD_EN
    // reload with a sample accepted in the same cycle
    for (int i = 0; i < 80; i++) go(1'b0, 1'b0, 0, 1'b1, 300 + i, 1'b0);
    go(1'b0, 1'b0, 0, 1'b1, 999, 1'b1);
    chk("reload_coef_ready", coef_ready, 1);
    chk("reload_primed", primed, 0);
    chk("reload_busy", busy, 1);
    load_random(1000);
    fs_count = 0;
    for (int n = 0; n < TAPS + 5; n++) go(1'b0, 1'b0, 0, 1'b1, 2000 + n, 1'b0);
    idle(3);
    chk("reload_frames", fs_count, 6);
`endif

    idle(4);
    chk("coef_queue_empty", cq.size(), 0);
    chk("samp_queue_empty", xq.size(), 0);
    chk("frame_queue_empty", fq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
